// File: rtl/cg_addr_sequencer_if.sv
// Bus bundle for cg_addr_sequencer: solve control, address-advance strobes and generated addresses.
// cycle_count is present only when CG_ADDR_SEQ_CYCLE_COUNT_EN is defined.
interface cg_addr_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int ITER_W = 11
);
  logic              start;
  logic [ADDR_W-1:0] total;
  logic              a_stream_en;
  logic              p_rd_adv;
  logic              r_rd_adv;
  logic              x_rd_adv;
  logic              p_wr_en;
  logic              r_wr_en;
  logic              x_wr_en;
  logic              alu_done;
  logic              converged;

  logic [ADDR_W-1:0] a_rd_addr;
  logic [ADDR_W-1:0] p_rd_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] x_rd_addr;
  logic [ADDR_W-1:0] p_wr_addr;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] x_wr_addr;
  logic              p_we;
  logic              r_we;
  logic              x_we;
  logic              busy;
  logic              halt;
  logic [ITER_W-1:0] iteration;
  logic              wrap_err;
`ifdef CG_ADDR_SEQ_CYCLE_COUNT_EN
  logic [31:0]       cycle_count;
`endif

  // The solver controller drives the strobes and consumes the addresses.
  modport master (
`ifdef CG_ADDR_SEQ_CYCLE_COUNT_EN
    input  cycle_count,
`endif
    output start, total, a_stream_en, p_rd_adv, r_rd_adv, x_rd_adv,
    output p_wr_en, r_wr_en, x_wr_en, alu_done, converged,
    input  a_rd_addr, p_rd_addr, r_rd_addr, x_rd_addr,
    input  p_wr_addr, r_wr_addr, x_wr_addr, p_we, r_we, x_we,
    input  busy, halt, iteration, wrap_err
  );

  modport slave (
`ifdef CG_ADDR_SEQ_CYCLE_COUNT_EN
    output cycle_count,
`endif
    input  start, total, a_stream_en, p_rd_adv, r_rd_adv, x_rd_adv,
    input  p_wr_en, r_wr_en, x_wr_en, alu_done, converged,
    output a_rd_addr, p_rd_addr, r_rd_addr, x_rd_addr,
    output p_wr_addr, r_wr_addr, x_wr_addr, p_we, r_we, x_we,
    output busy, halt, iteration, wrap_err
  );
endinterface

// File: rtl/cg_addr_sequencer.sv
// Address sequencer for a CG solver: per-memory read/write address generation across iterations.
// Define CG_ADDR_SEQ_CYCLE_COUNT_EN to add a saturating RUN-cycle counter output.
module cg_addr_sequencer #(
  parameter int NUM_UNITS = 8,
  parameter int ADDR_W    = 32,
  parameter int ITER_W    = 11,
  parameter int MAX_ITER  = 1024
) (
  input  logic clk,
  input  logic reset,
  cg_addr_sequencer_if.slave bus
);

  localparam int                LOG2_UNITS = $clog2(NUM_UNITS);
  localparam logic [ADDR_W-1:0] UNIT_MASK  = ADDR_W'(NUM_UNITS - 1);
  localparam logic [ITER_W-1:0] LAST_ITER  = ITER_W'(MAX_ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_W-1:0]   depth;
  logic [ADDR_W-1:0]   a_limit;
  logic [ADDR_W-1:0]   a_rd_q;
  logic [ADDR_W-1:0]   p_rd_q;
  logic [ADDR_W-1:0]   r_rd_q;
  logic [ADDR_W-1:0]   x_rd_q;
  logic [ADDR_W-1:0]   p_wr_q;
  logic [ADDR_W-1:0]   r_wr_q;
  logic [ADDR_W-1:0]   x_wr_q;
  logic [ITER_W-1:0]   iteration_q;
  logic                wrap_err_q;

  logic                running;
  logic                start_ok;
  logic                start_zero;
  logic                total_zero;
  logic                last_iter;
  logic                p_we_int;
  logic                r_we_int;
  logic                x_we_int;
  logic [ADDR_W-1:0]   depth_new;
  logic [2*ADDR_W-1:0] a_prod;
  logic [ADDR_W-1:0]   a_limit_new;

  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] cur,
                                                  input logic [ADDR_W-1:0] limit);
    return (cur == limit - ADDR_W'(1)) ? '0 : cur + ADDR_W'(1);
  endfunction

  assign running    = (state == RUN);
  assign total_zero = (bus.total == '0);
  assign start_ok   = bus.start && !total_zero && !running;
  assign start_zero = bus.start && total_zero && !running;
  assign last_iter  = (iteration_q == LAST_ITER);

  // Depth rounds up so a partial final word still gets its own address.
  assign depth_new   = (bus.total >> LOG2_UNITS) + ADDR_W'(|(bus.total & UNIT_MASK));
  assign a_prod      = {{ADDR_W{1'b0}}, depth_new} * {{ADDR_W{1'b0}}, bus.total};
  assign a_limit_new = (|a_prod[2*ADDR_W-1:ADDR_W]) ? '1 : a_prod[ADDR_W-1:0];

  assign p_we_int = bus.p_wr_en && running;
  assign r_we_int = bus.r_wr_en && running;
  assign x_we_int = bus.x_wr_en && running;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, HALT: begin
        if (start_ok) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (bus.alu_done && (bus.converged || last_iter)) begin
          state_nxt = HALT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // alu_done wins over every advance and write in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      depth       <= '0;
      a_limit     <= '0;
      a_rd_q      <= '0;
      p_rd_q      <= '0;
      r_rd_q      <= '0;
      x_rd_q      <= '0;
      p_wr_q      <= '0;
      r_wr_q      <= '0;
      x_wr_q      <= '0;
      iteration_q <= '0;
      wrap_err_q  <= 1'b0;
    end else begin
      wrap_err_q <= start_zero;
      if (start_ok) begin
        depth       <= depth_new;
        a_limit     <= a_limit_new;
        a_rd_q      <= '0;
        p_rd_q      <= '0;
        r_rd_q      <= '0;
        x_rd_q      <= '0;
        p_wr_q      <= '0;
        r_wr_q      <= '0;
        x_wr_q      <= '0;
        iteration_q <= '0;
      end else if (running) begin
        if (bus.alu_done) begin
          a_rd_q      <= '0;
          p_rd_q      <= '0;
          r_rd_q      <= '0;
          x_rd_q      <= '0;
          p_wr_q      <= '0;
          r_wr_q      <= '0;
          x_wr_q      <= '0;
          iteration_q <= iteration_q + ITER_W'(1);
        end else begin
          if (bus.a_stream_en) a_rd_q <= wrap_inc(a_rd_q, a_limit);
          if (bus.p_rd_adv)    p_rd_q <= wrap_inc(p_rd_q, depth);
          if (bus.r_rd_adv)    r_rd_q <= wrap_inc(r_rd_q, depth);
          if (bus.x_rd_adv)    x_rd_q <= wrap_inc(x_rd_q, depth);
          if (p_we_int)        p_wr_q <= wrap_inc(p_wr_q, depth);
          if (r_we_int)        r_wr_q <= wrap_inc(r_wr_q, depth);
          if (x_we_int)        x_wr_q <= wrap_inc(x_wr_q, depth);
        end
      end
    end
  end

`ifdef CG_ADDR_SEQ_CYCLE_COUNT_EN
  logic [31:0] cycle_count_q;

  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      cycle_count_q <= '0;
    end else if (running && (cycle_count_q != 32'hFFFF_FFFF)) begin
      cycle_count_q <= cycle_count_q + 32'd1;
    end
  end

  assign bus.cycle_count = cycle_count_q;
`endif

  assign bus.a_rd_addr = a_rd_q;
  assign bus.p_rd_addr = p_rd_q;
  assign bus.r_rd_addr = r_rd_q;
  assign bus.x_rd_addr = x_rd_q;
  assign bus.p_wr_addr = p_wr_q;
  assign bus.r_wr_addr = r_wr_q;
  assign bus.x_wr_addr = x_wr_q;
  assign bus.p_we      = p_we_int;
  assign bus.r_we      = r_we_int;
  assign bus.x_we      = x_we_int;
  assign bus.busy      = running;
  assign bus.halt      = (state == HALT);
  assign bus.iteration = iteration_q;
  assign bus.wrap_err  = wrap_err_q;

endmodule

// File: tb/tb_cg_addr_sequencer.sv
// Bench for cg_addr_sequencer: directed scenarios plus randomized traffic against a queue-free
// arithmetic model of the solve; a second instance with MAX_ITER=4 covers the iteration limit.
module tb_cg_addr_sequencer;

  localparam int ADDR_W    = 32;
  localparam int ITER_W    = 11;
  localparam int NUM_UNITS = 8;
  localparam int MAX_ITER  = 1024;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  cg_addr_sequencer_if #(.ADDR_W(ADDR_W), .ITER_W(ITER_W)) ifc ();
  cg_addr_sequencer_if #(.ADDR_W(ADDR_W), .ITER_W(ITER_W)) ifc4 ();

  cg_addr_sequencer #(
    .NUM_UNITS(NUM_UNITS), .ADDR_W(ADDR_W), .ITER_W(ITER_W), .MAX_ITER(MAX_ITER)
  ) u_dut (
    .clk(clk), .reset(reset), .bus(ifc)
  );

  cg_addr_sequencer #(
    .NUM_UNITS(NUM_UNITS), .ADDR_W(ADDR_W), .ITER_W(ITER_W), .MAX_ITER(4)
  ) u_dut4 (
    .clk(clk), .reset(reset), .bus(ifc4)
  );

  int total_checks = 0;
  int bad_checks   = 0;

  // Reference state: solving/halted flags, vector geometry and the seven addresses as integers.
  bit     m_run  = 0;
  bit     m_halt = 0;
  bit     m_wrap = 0;
  bit     m_acc;
  longint m_depth = 0;
  longint m_alim  = 0;
  longint m_a     = 0;
  longint m_rd[3] = '{0, 0, 0};
  longint m_wr[3] = '{0, 0, 0};
  longint m_iter  = 0;
  longint m_cyc   = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total_checks++;
    if (actual !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock: inputs set beforehand are consumed on the rising edge, outputs are read after the fall.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    ifc.start       = 1'b0;
    ifc.total       = '0;
    ifc.a_stream_en = 1'b0;
    ifc.p_rd_adv    = 1'b0;
    ifc.r_rd_adv    = 1'b0;
    ifc.x_rd_adv    = 1'b0;
    ifc.p_wr_en     = 1'b0;
    ifc.r_wr_en     = 1'b0;
    ifc.x_wr_en     = 1'b0;
    ifc.alu_done    = 1'b0;
    ifc.converged   = 1'b0;
  endtask

  task automatic model_clear_addrs();
    m_a = 0;
    for (int i = 0; i < 3; i++) begin
      m_rd[i] = 0;
      m_wr[i] = 0;
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_run = 0; m_halt = 0; m_wrap = 0;
      m_depth = 0; m_alim = 0; m_iter = 0; m_cyc = 0;
      model_clear_addrs();
    end else begin
      m_acc  = ifc.start && (ifc.total != 0) && !m_run;
      m_wrap = ifc.start && (ifc.total == 0) && !m_run;
      if (m_acc) begin
        m_depth = (longint'(ifc.total) + NUM_UNITS - 1) / NUM_UNITS;
        m_alim  = m_depth * longint'(ifc.total);
        if (m_alim > 64'hFFFF_FFFF) m_alim = 64'hFFFF_FFFF;
        model_clear_addrs();
        m_iter = 0; m_cyc = 0; m_run = 1; m_halt = 0;
      end else if (m_run) begin
        if (m_cyc < 64'hFFFF_FFFF) m_cyc = m_cyc + 1;
        if (ifc.alu_done) begin
          model_clear_addrs();
          m_iter = m_iter + 1;
          if (ifc.converged || m_iter == MAX_ITER) begin
            m_run = 0; m_halt = 1;
          end
        end else begin
          if (ifc.a_stream_en) m_a = (m_a + 1) % m_alim;
          if (ifc.p_rd_adv)    m_rd[0] = (m_rd[0] + 1) % m_depth;
          if (ifc.r_rd_adv)    m_rd[1] = (m_rd[1] + 1) % m_depth;
          if (ifc.x_rd_adv)    m_rd[2] = (m_rd[2] + 1) % m_depth;
          if (ifc.p_wr_en)     m_wr[0] = (m_wr[0] + 1) % m_depth;
          if (ifc.r_wr_en)     m_wr[1] = (m_wr[1] + 1) % m_depth;
          if (ifc.x_wr_en)     m_wr[2] = (m_wr[2] + 1) % m_depth;
        end
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("a_rd_addr", ifc.a_rd_addr, m_a);
    checkOutput("p_rd_addr", ifc.p_rd_addr, m_rd[0]);
    checkOutput("r_rd_addr", ifc.r_rd_addr, m_rd[1]);
    checkOutput("x_rd_addr", ifc.x_rd_addr, m_rd[2]);
    checkOutput("p_wr_addr", ifc.p_wr_addr, m_wr[0]);
    checkOutput("r_wr_addr", ifc.r_wr_addr, m_wr[1]);
    checkOutput("x_wr_addr", ifc.x_wr_addr, m_wr[2]);
    checkOutput("p_we", ifc.p_we, 64'(ifc.p_wr_en && m_run));
    checkOutput("r_we", ifc.r_we, 64'(ifc.r_wr_en && m_run));
    checkOutput("x_we", ifc.x_we, 64'(ifc.x_wr_en && m_run));
    checkOutput("busy", ifc.busy, 64'(m_run));
    checkOutput("halt", ifc.halt, 64'(m_halt));
    checkOutput("iteration", ifc.iteration, m_iter);
    checkOutput("wrap_err", ifc.wrap_err, 64'(m_wrap));
`ifdef CG_ADDR_SEQ_CYCLE_COUNT_EN
    checkOutput("cycle_count", ifc.cycle_count, m_cyc);
`endif
  end

  initial begin
    int seq_p[9];
    int seq_r[3];
    seq_p = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
    seq_r = '{1, 2, 0};

    clear_inputs();
    ifc4.start = 1'b0; ifc4.total = '0; ifc4.a_stream_en = 1'b0;
    ifc4.p_rd_adv = 1'b0; ifc4.r_rd_adv = 1'b0; ifc4.x_rd_adv = 1'b0;
    ifc4.p_wr_en = 1'b0; ifc4.r_wr_en = 1'b0; ifc4.x_wr_en = 1'b0;
    ifc4.alu_done = 1'b0; ifc4.converged = 1'b0;
    reset = 1'b1;
    applyStimulus(2);
    checkOutput("rst_busy", ifc.busy, 0);
    checkOutput("rst_halt", ifc.halt, 0);
    checkOutput("rst_iteration", ifc.iteration, 0);
    checkOutput("rst_wrap_err", ifc.wrap_err, 0);
    reset = 1'b0;

    // total=64 gives depth 8; p_rd_addr walks 1..7 then wraps.
    ifc.start = 1'b1; ifc.total = 64;
    applyStimulus(1);
    ifc.start = 1'b0;
    checkOutput("s1_busy", ifc.busy, 1);
    ifc.p_rd_adv = 1'b1;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1);
      checkOutput("s1_p_rd_addr", ifc.p_rd_addr, seq_p[i]);
    end
    ifc.p_rd_adv = 1'b0;

    // total=20 rounds up to depth 3; the A stream wraps at 3*20=60.
    reset = 1'b1;
    applyStimulus(1);
    reset = 1'b0;
    ifc.start = 1'b1; ifc.total = 20;
    applyStimulus(1);
    ifc.start = 1'b0;
    ifc.r_wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      checkOutput("s2_r_we", ifc.r_we, 1);
      checkOutput("s2_r_wr_addr", ifc.r_wr_addr, seq_r[i]);
    end
    ifc.r_wr_en = 1'b0;
    ifc.a_stream_en = 1'b1;
    applyStimulus(59);
    checkOutput("s2_a_rd_last", ifc.a_rd_addr, 59);
    applyStimulus(1);
    checkOutput("s2_a_rd_wrap", ifc.a_rd_addr, 0);
    ifc.a_stream_en = 1'b0;

    ifc.x_rd_adv = 1'b1;
    applyStimulus(1);
    checkOutput("s3_x_rd_pre", ifc.x_rd_addr, 1);
    ifc.alu_done = 1'b1;
    applyStimulus(1);
    clear_inputs();
    checkOutput("s3_x_rd_addr", ifc.x_rd_addr, 0);
    checkOutput("s3_iteration", ifc.iteration, 1);
    checkOutput("s3_busy", ifc.busy, 1);

    ifc.alu_done = 1'b1;
    applyStimulus(4);
    ifc.alu_done = 1'b0;
    checkOutput("s4_iter5", ifc.iteration, 5);
    ifc.alu_done = 1'b1; ifc.converged = 1'b1;
    applyStimulus(1);
    clear_inputs();
    checkOutput("s4_halt", ifc.halt, 1);
    checkOutput("s4_busy", ifc.busy, 0);
    checkOutput("s4_iteration", ifc.iteration, 6);
    ifc.p_wr_en = 1'b1; ifc.p_rd_adv = 1'b1;
    applyStimulus(1);
    checkOutput("s4_p_we", ifc.p_we, 0);
    checkOutput("s4_p_wr_hold", ifc.p_wr_addr, 0);
    checkOutput("s4_p_rd_hold", ifc.p_rd_addr, 0);
    clear_inputs();
    ifc.start = 1'b1; ifc.total = 8;
    applyStimulus(1);
    ifc.start = 1'b0;
    checkOutput("s4_restart_busy", ifc.busy, 1);
    checkOutput("s4_restart_iter", ifc.iteration, 0);

    reset = 1'b1;
    applyStimulus(1);
    reset = 1'b0;
    ifc.start = 1'b1; ifc.total = 0;
    applyStimulus(1);
    ifc.start = 1'b0;
    checkOutput("s6_wrap_err", ifc.wrap_err, 1);
    checkOutput("s6_busy", ifc.busy, 0);
    applyStimulus(1);
    checkOutput("s6_wrap_err_clr", ifc.wrap_err, 0);
    ifc.start = 1'b1; ifc.total = 64;
    applyStimulus(1);
    ifc.start = 1'b0; ifc.alu_done = 1'b1;
    applyStimulus(1);
    ifc.alu_done = 1'b0;
    ifc.a_stream_en = 1'b1; ifc.p_rd_adv = 1'b1; ifc.x_wr_en = 1'b1;
    applyStimulus(3);
    checkOutput("s6_pre_p_rd", ifc.p_rd_addr, 3);
    reset = 1'b1; ifc.start = 1'b1; ifc.alu_done = 1'b1;
    applyStimulus(1);
    checkOutput("s6_rst_busy", ifc.busy, 0);
    checkOutput("s6_rst_iter", ifc.iteration, 0);
    checkOutput("s6_rst_p_rd", ifc.p_rd_addr, 0);
    checkOutput("s6_rst_a_rd", ifc.a_rd_addr, 0);
    checkOutput("s6_rst_x_wr", ifc.x_wr_addr, 0);
    clear_inputs();
    reset = 1'b0;

    // Iteration limit of 4 on the second instance, never converging.
    ifc4.start = 1'b1; ifc4.total = 8;
    applyStimulus(1);
    ifc4.start = 1'b0; ifc4.alu_done = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1);
      checkOutput("s5_iteration", ifc4.iteration, i);
      checkOutput("s5_halt", ifc4.halt, (i == 4) ? 1 : 0);
    end
    checkOutput("s5_busy", ifc4.busy, 0);
    ifc4.alu_done = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      clear_inputs();
      reset = ($urandom_range(0, 399) == 0);
      if (!m_run) begin
        ifc.start = ($urandom_range(0, 5) == 0);
        ifc.total = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 90);
      end else if ($urandom_range(0, 39) == 0) begin
        ifc.start = 1'b1;
        ifc.total = $urandom_range(1, 90);
      end
      ifc.a_stream_en = 1'($urandom_range(0, 1));
      ifc.p_rd_adv    = 1'($urandom_range(0, 1));
      ifc.r_rd_adv    = 1'($urandom_range(0, 1));
      ifc.x_rd_adv    = 1'($urandom_range(0, 1));
      ifc.p_wr_en     = 1'($urandom_range(0, 1));
      ifc.r_wr_en     = 1'($urandom_range(0, 1));
      ifc.x_wr_en     = 1'($urandom_range(0, 1));
      ifc.alu_done    = ($urandom_range(0, 24) == 0);
      ifc.converged   = ($urandom_range(0, 3) == 0);
      applyStimulus(1);
    end
    clear_inputs();
    reset = 1'b0;
    applyStimulus(2);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
